// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, with a
// valid/ready handshake on operands and result.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready = 1)
// RUN   | shifting/subtracting, one quotient bit per cycle
// DONE  | result held on the outputs until out_ready (out_valid = 1)
module seq_divider #(
  parameter int WL = 32,
  parameter int WS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] dividend,
  input  logic [WS-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] quotient,
  output logic [WS-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(WL + 1);

  if (WS > WL) begin : g_ws_check
    $error("seq_divider: WS must not exceed WL");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WL-1:0] dvd_q, dvd_d;
  logic [WL-1:0] orig_q, orig_d;
  logic [WS-1:0] dvsr_q, dvsr_d;
  logic [WS:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;
  logic [WS:0]   rem_shift;
  logic          fits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      orig_q  <= '0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      orig_q  <= orig_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // The dividend register shifts out numerator bits at the top and collects
  // quotient bits at the bottom, so after WL steps it holds the quotient.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    orig_d    = orig_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    rem_shift = {rem_q[WS-1:0], dvd_q[WL-1]};
    fits      = (rem_shift >= {1'b0, dvsr_q});
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          orig_d = dividend;
          dvsr_d = divisor;
          cnt_d  = '0;
          if (divisor == '0) begin
            dvd_d   = '1;
            rem_d   = {1'b0, dividend[WS-1:0]};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        dvd_d = {dvd_q[WL-2:0], fits};
        rem_d = fits ? (rem_shift - {1'b0, dvsr_q}) : rem_shift;
        if (cnt_q == CW'(WL - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = dvd_q;
  assign remainder   = rem_q[WS-1:0];
  assign div_by_zero = dbz_q;

  logic [2*WL-1:0] recon;
  assign recon = (2*WL)'(dvd_q) * (2*WL)'(dvsr_q) + (2*WL)'(rem_q);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(in_ready && out_valid));
      if (state_q == DONE && !dbz_q) begin
        assert (recon == (2*WL)'(orig_q));
        assert (rem_q < {1'b0, dvsr_q});
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table plus scoreboard queue, with hand-written
// sequences for result hold, reset abort and no-bypass release.
module tb_seq_divider;

  localparam int WL = 32;
  localparam int WS = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] dividend;
  logic [WS-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] quotient;
  logic [WS-1:0] remainder;
  logic          div_by_zero;

  seq_divider #(.WL(WL), .WS(WS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WL-1:0] q;
    logic [WS-1:0] r;
    logic          z;
  } res_t;

  typedef struct {
    logic [WL-1:0] a;
    logic [WS-1:0] b;
    logic [WL-1:0] q;
    logic [WS-1:0] r;
    logic          z;
    int            hold;
  } vec_t;

  vec_t tbl[10];
  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [WL-1:0] a, input logic [WS-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a[WS-1:0];
      e.z = 1'b1;
    end else begin
      e.q = a / WL'(b);
      e.r = WS'(a % WL'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Drives one operation with junk operands and in_valid held high while busy,
  // then checks latency, result, hold stability and the release to IDLE.
  task automatic run_op(input logic [WL-1:0] a, input logic [WS-1:0] b,
                        input res_t e, input int hold);
    int   lat;
    int   guard;
    logic seen;
    res_t got;
    sb.push_back(e);
    out_ready = (hold == 0);
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    dividend = $urandom;
    divisor  = WS'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      seen = out_valid;
    end
    check("out_valid_seen", 64'(seen), 64'd1);
    if (!seen) begin
      in_valid = 1'b0;
      got = sb.pop_front();
      return;
    end
    check("latency", 64'(lat), (b == '0) ? 64'd1 : 64'(WL + 1));
    got = sb.pop_front();
    check("quotient", 64'(quotient), 64'(got.q));
    check("remainder", 64'(remainder), 64'(got.r));
    check("div_by_zero", 64'(div_by_zero), 64'(got.z));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_quotient", 64'(quotient), 64'(got.q));
      check("hold_remainder", 64'(remainder), 64'(got.r));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("release_idle", 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stray;
    res_t e;
    logic [WL-1:0] ra;
    logic [WS-1:0] rb;

    tbl[0] = '{32'd100,        16'd7,      32'd14,         16'd2,      1'b0, 0};
    tbl[1] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'd0,      1'b0, 0};
    tbl[2] = '{32'd5,          16'd0,      32'hFFFF_FFFF,  16'd5,      1'b1, 0};
    tbl[3] = '{32'd3,          16'd9,      32'd0,          16'd3,      1'b0, 10};
    tbl[4] = '{32'd0,          16'd13,     32'd0,          16'd0,      1'b0, 0};
    tbl[5] = '{32'd12345,      16'd1,      32'd12345,      16'd0,      1'b0, 1};
    tbl[6] = '{32'd1000000,    16'hFFFF,   32'd15,         16'd16975,  1'b0, 0};
    tbl[7] = '{32'hFFFF_FFFF,  16'h8000,   32'h0001_FFFF,  16'h7FFF,   1'b0, 2};
    tbl[8] = '{32'hABCD_1234,  16'd0,      32'hFFFF_FFFF,  16'h1234,   1'b1, 3};
    tbl[9] = '{32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_div_by_zero", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e.q = tbl[i].q;
      e.r = tbl[i].r;
      e.z = tbl[i].z;
      run_op(tbl[i].a, tbl[i].b, e, tbl[i].hold);
    end

    // Abort an operation mid-run: no result may surface afterwards.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort_no_stale_valid", 64'(stray), 64'd0);
    e.q = 32'd10;
    e.r = 16'd0;
    e.z = 1'b0;
    run_op(32'd50, 16'd5, e, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? WS'($urandom_range(1, 15)) : WS'($urandom);
      run_op(ra, rb, model(ra, rb), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WL, default 32: dividend and quotient width in bits.
REQ-002 Parameter WS, default 16: divisor and remainder width in bits; the design SHALL require WS <= WL.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 dividend  input  WL  unsigned numerator.
REQ-008 divisor  input  WS  unsigned denominator.
REQ-009 out_valid  output  1  result held on the outputs.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  WL  unsigned quotient.
REQ-012 remainder  output  WS  unsigned remainder.
REQ-013 div_by_zero  output  1  the current result came from divisor == 0.

Function
REQ-014 The block SHALL be the inverse counterpart of the team's multiplier: an unsigned restoring divider producing one quotient bit per cycle.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-017 Accept: in IDLE with in_valid=1, the block SHALL latch dividend and divisor, clear the partial remainder (WS+1 bits) and the bit counter, and move to RUN, or to DONE if divisor == 0.
REQ-018 RUN step, cycles 1..WL after accept, MSB first:
- shift {partial remainder, dividend register} left by 1;
- if shifted partial remainder >= divisor, subtract the divisor and set the quotient LSB to 1, else set it to 0.
REQ-019 After the WL-th RUN step the block SHALL enter DONE, so out_valid rises exactly WL+1 cycles after the accept edge.
REQ-020 Divide by zero: the block SHALL reach DONE one cycle after accept with quotient = all ones, remainder = dividend[WS-1:0] and div_by_zero = 1.
REQ-021 In DONE, quotient, remainder and div_by_zero SHALL stay stable while out_ready = 0, with no timeout.
REQ-022 In DONE with out_ready = 1, the block SHALL return to IDLE on the next cycle; a new operand SHALL NOT be accepted in that same cycle (no bypass).
REQ-023 in_valid SHALL be ignored in RUN and DONE, and operand input changes during RUN SHALL NOT affect the result.
REQ-024 Boundary results:
- dividend = 0 gives quotient 0 and remainder 0;
- divisor = 1 gives quotient = dividend and remainder 0;
- dividend < divisor gives quotient 0 and remainder = dividend.
REQ-025 The arithmetic SHALL keep the partial remainder at WS+1 bits so that no comparison or subtraction overflows for divisor = 2^WS-1.
REQ-026 Embedded immediate assertions, checked only when rst_n=1, in DONE and div_by_zero=0:
- quotient * divisor + remainder == latched dividend, evaluated at 2*WL bits;
- remainder < latched divisor.
REQ-027 Embedded assertion: out_valid and in_ready SHALL never both be 1.

Reset
REQ-028 With rst_n=0 at a clock edge, the next state SHALL be IDLE; quotient, remainder, all internal registers, out_valid and div_by_zero SHALL be 0; in_ready SHALL be 1.
REQ-029 Reset in RUN or DONE SHALL abort the operation, with no result and no out_valid pulse afterwards.
REQ-030 Embedded assertions SHALL be suppressed during a reset cycle.

Verification
REQ-031 Dividend 100, divisor 7, out_ready=1 -> out_valid in cycle WL+1 after accept, quotient 14, remainder 2, div_by_zero 0.
REQ-032 Dividend 0xFFFFFFFF, divisor 0xFFFF -> quotient 0x00010001, remainder 0.
REQ-033 Dividend 5, divisor 0 -> DONE 1 cycle after accept, quotient 0xFFFFFFFF, remainder 5, div_by_zero 1.
REQ-034 Dividend 3, divisor 9, out_ready held 0 for 10 cycles -> quotient 0 and remainder 3 stable throughout; IDLE one cycle after out_ready rises.
REQ-035 rst_n pulsed low at RUN cycle 5, then dividend 50, divisor 5 -> no stale out_valid; next result quotient 10, remainder 0.
REQ-036 Formal: the REQ-026 and REQ-027 assertions SHALL be proven unbounded for WL=8, WS=4 and bounded to depth 2*WL+4 at the defaults.
